// File: rtl/cam_fb_defs_pkg.sv
// ============================================================================
// Module      : cam_fb_defs_pkg
// Description : Register map, FSM encodings, pixel-format codes and STATUS
//               bit positions shared by the camera frame-buffer peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cam_fb_defs_pkg;

    localparam logic [3:0] c_reg_ctrl   = 4'h0;
    localparam logic [3:0] c_reg_raddr  = 4'h2;
    localparam logic [3:0] c_reg_rdata  = 4'h4;
    localparam logic [3:0] c_reg_status = 4'h6;
    localparam logic [3:0] c_reg_count  = 4'h8;
    localparam logic [3:0] c_reg_abort  = 4'hA;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_arm  = 2'd1;
    localparam logic [1:0] c_st_cap  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    localparam logic [1:0] c_fmt_rgb565 = 2'd0;
    localparam logic [1:0] c_fmt_gray   = 2'd1;
    localparam logic [1:0] c_fmt_raw    = 2'd2;

    localparam int c_stat_busy     = 0;
    localparam int c_stat_done     = 1;
    localparam int c_stat_ovf      = 2;
    localparam int c_stat_fcnt_lsb = 8;

endpackage

`default_nettype wire

// File: rtl/cam_fb_ram.sv
// ============================================================================
// Module      : cam_fb_ram
// Description : Simple dual-port frame-buffer RAM, one write port and one
//               registered read port (read-first on address collision).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_fb_ram #(
    parameter int DW = 16,
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(2**AW)-1];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/peripheral_cam_fb.sv
// ============================================================================
// Module      : peripheral_cam_fb
// Description : J1 camera frame-capture peripheral with format conversion,
//               auto-incrementing readout, overflow/frame counting and abort.
//               Optional macro CAM_DECIMATE_EN enables 2:1 horizontal decimation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module peripheral_cam_fb #(
    parameter int IN_W   = 24,
    parameter int MEM_W  = 16,
    parameter int AW     = 14,
    parameter int FCNT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     d_in,
    input  logic            cs,
    input  logic [3:0]      addr,
    input  logic            rd,
    input  logic            wr,
    output logic [15:0]     d_out,
    input  logic            vsync,
    input  logic            href,
    input  logic            pixel_valid,
    input  logic [IN_W-1:0] pixel_data,
    output logic            irq
);
    import cam_fb_defs_pkg::*;

    localparam logic [AW:0] c_wptr_full = {1'b1, {AW{1'b0}}};

    logic              r_vsync_q;
    logic [1:0]        r_state;
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_count;
    logic [AW-1:0]     r_rptr;
    logic [FCNT_W-1:0] r_fcnt;
    logic              r_done;
    logic              r_ovf;
    logic              r_cont;
    logic [1:0]        r_fmt;
    logic [15:0]       r_d_out;

    logic              w_wr_sel, w_rd_sel, w_ctrl_wr, w_start, w_abort;
    logic              w_frame_edge, w_pix_in, w_keep, w_decim_rb;
    logic              w_we;
    logic [AW-1:0]     w_waddr;
    logic [MEM_W-1:0]  w_wdata;
    logic [MEM_W-1:0]  w_ram_q;
    logic [23:0]       w_px24;
    logic [15:0]       w_status;
    logic [15:0]       w_ctrl_rb;
    logic              w_unused;

    assign w_wr_sel     = cs && wr;
    assign w_rd_sel     = cs && rd;
    assign w_ctrl_wr    = w_wr_sel && (addr == c_reg_ctrl);
    assign w_start      = w_ctrl_wr && d_in[0];
    assign w_abort      = w_wr_sel && (addr == c_reg_abort);
    assign w_frame_edge = vsync && !r_vsync_q;
    assign w_pix_in     = pixel_valid && href;

    generate
        if (IN_W >= 24) begin : g_px_trunc
            assign w_px24 = pixel_data[23:0];
        end else begin : g_px_ext
            assign w_px24 = {{(24-IN_W){1'b0}}, pixel_data};
        end
    endgenerate

`ifdef CAM_DECIMATE_EN
    logic r_decim;
    logic r_phase;

    // Phase restarts at every line so the first pixel of each line is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_decim <= 1'b0;
            r_phase <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_decim <= d_in[4];
            end
            if (!href) begin
                r_phase <= 1'b0;
            end else if (w_pix_in && r_decim) begin
                r_phase <= ~r_phase;
            end
        end
    end

    assign w_keep     = w_pix_in && !(r_decim && r_phase);
    assign w_decim_rb = r_decim;
`else
    assign w_keep     = w_pix_in;
    assign w_decim_rb = 1'b0;
`endif

    always_comb begin
        case (r_fmt)
            c_fmt_gray: w_wdata = {8'h00, w_px24[15:8]};
            c_fmt_raw:  w_wdata = w_px24[15:0];
            default:    w_wdata = {w_px24[23:19], w_px24[15:10], w_px24[7:3]};
        endcase
    end

    // A pixel coinciding with a boundary opens the next frame at address 0.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_wptr[AW-1:0];
        if (!rst && !w_abort && !w_start && w_keep) begin
            if (w_frame_edge) begin
                if ((r_state == c_st_arm) || ((r_state == c_st_cap) && r_cont)) begin
                    w_we    = 1'b1;
                    w_waddr = '0;
                end
            end else if ((r_state == c_st_cap) && (r_wptr != c_wptr_full)) begin
                w_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync_q <= 1'b0;
            r_state   <= c_st_idle;
            r_wptr    <= '0;
            r_count   <= '0;
            r_fcnt    <= '0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_cont    <= 1'b0;
            r_fmt     <= c_fmt_rgb565;
        end else begin
            r_vsync_q <= vsync;
            if (w_ctrl_wr) begin
                r_cont <= d_in[1];
                r_fmt  <= d_in[3:2];
                r_done <= 1'b0;
                r_ovf  <= 1'b0;
            end
            if (w_abort) begin
                r_state <= c_st_idle;
            end else if (w_start) begin
                r_state <= c_st_arm;
            end else begin
                case (r_state)
                    c_st_arm: begin
                        if (w_frame_edge) begin
                            r_state <= c_st_cap;
                            r_wptr  <= {{AW{1'b0}}, w_we};
                        end
                    end
                    c_st_cap: begin
                        if (w_frame_edge) begin
                            r_count <= r_wptr;
                            r_fcnt  <= r_fcnt + 1'b1;
                            if (r_cont) begin
                                r_done <= 1'b1;
                                r_wptr <= {{AW{1'b0}}, w_we};
                            end else begin
                                r_state <= c_st_done;
                            end
                        end else if (w_keep) begin
                            if (r_wptr == c_wptr_full) begin
                                r_ovf <= 1'b1;
                            end else begin
                                r_wptr <= r_wptr + 1'b1;
                            end
                        end
                    end
                    c_st_done: begin
                        r_done  <= 1'b1;
                        r_state <= c_st_idle;
                    end
                    default: r_state <= c_st_idle;
                endcase
            end
        end
    end

    cam_fb_ram #(
        .DW (MEM_W),
        .AW (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (r_rptr),
        .o_rdata (w_ram_q)
    );

    always_comb begin
        w_status                          = '0;
        w_status[c_stat_busy]             = (r_state != c_st_idle);
        w_status[c_stat_done]             = r_done;
        w_status[c_stat_ovf]              = r_ovf;
        w_status[c_stat_fcnt_lsb +: 8]    = 8'(r_fcnt);
    end

    assign w_ctrl_rb = {11'b0, w_decim_rb, r_fmt, r_cont, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_out <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_wr_sel && (addr == c_reg_raddr)) begin
                r_rptr <= d_in[AW-1:0];
            end
            if (w_rd_sel) begin
                case (addr)
                    c_reg_rdata: begin
                        r_d_out <= 16'(w_ram_q);
                        r_rptr  <= r_rptr + 1'b1;
                    end
                    c_reg_status: r_d_out <= w_status;
                    c_reg_count:  r_d_out <= 16'(r_count);
                    c_reg_ctrl:   r_d_out <= w_ctrl_rb;
                    default:      r_d_out <= '0;
                endcase
            end
        end
    end

    assign d_out    = r_d_out;
    assign irq      = r_done;
    assign w_unused = ^{d_in, 1'b0};

endmodule

`default_nettype wire

// File: tb/tb_peripheral_cam_fb.sv
// ============================================================================
// Module      : tb_peripheral_cam_fb
// Description : Self-checking bench for peripheral_cam_fb (AW=4, DEPTH=16).
//               Build with CAM_DECIMATE_EN to exercise decimation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_peripheral_cam_fb;

    localparam logic [3:0] A_CTRL = 4'h0, A_RADDR = 4'h2, A_RDATA = 4'h4;
    localparam logic [3:0] A_STATUS = 4'h6, A_COUNT = 4'h8, A_ABORT = 4'hA;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] d_in = '0;
    logic        cs = 1'b0;
    logic [3:0]  addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] d_out;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic        pixel_valid = 1'b0;
    logic [23:0] pixel_data = '0;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] sb_q[$];

    typedef struct {
        logic [23:0] pix;
        logic [1:0]  fmt;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[7];

    peripheral_cam_fb #(
        .IN_W   (24),
        .MEM_W  (16),
        .AW     (4),
        .FCNT_W (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .d_in        (d_in),
        .cs          (cs),
        .addr        (addr),
        .rd          (rd),
        .wr          (wr),
        .d_out       (d_out),
        .vsync       (vsync),
        .href        (href),
        .pixel_valid (pixel_valid),
        .pixel_data  (pixel_data),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; d_in = '0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [15:0] v);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        v = d_out;
    endtask

    task automatic reg_check(input string name, input logic [3:0] a, input logic [15:0] exp);
        logic [15:0] v;
        bus_read(a, v);
        check(name, v, exp);
    endtask

    task automatic sb_read(input string name);
        logic [15:0] v;
        bus_read(A_RDATA, v);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got 0x%04h, expected nothing (scoreboard empty)", name, v);
        end else begin
            check(name, v, sb_q.pop_front());
        end
    endtask

    task automatic send_pixel(input logic [23:0] p);
        @(negedge clk);
        pixel_valid = 1'b1; pixel_data = p;
        @(negedge clk);
        pixel_valid = 1'b0;
    endtask

    task automatic vsync_pulse();
        @(negedge clk);
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{24'hFF0000, 2'd0, 16'hF800};
        vecs[1] = '{24'h123456, 2'd1, 16'h0034};
        vecs[2] = '{24'h123456, 2'd2, 16'h3456};
        vecs[3] = '{24'h123456, 2'd3, 16'h11AA};
        vecs[4] = '{24'hABCDEF, 2'd0, 16'hAE7D};
        vecs[5] = '{24'hABCDEF, 2'd1, 16'h00CD};
        vecs[6] = '{24'hABCDEF, 2'd2, 16'hCDEF};

        // Reset state
        do_reset();
        check("reset_dout", d_out, 16'h0000);
        check("reset_irq", {15'b0, irq}, 16'h0000);
        reg_check("reset_status", A_STATUS, 16'h0000);
        reg_check("reset_count", A_COUNT, 16'h0000);

        // Four-pixel RGB565 frame
        bus_write(A_CTRL, 16'h0001);
        vsync_pulse();
        href = 1'b1;
        send_pixel(24'hFF0000); sb_q.push_back(16'hF800);
        send_pixel(24'h00FF00); sb_q.push_back(16'h07E0);
        send_pixel(24'h0000FF); sb_q.push_back(16'h001F);
        send_pixel(24'hFFFFFF); sb_q.push_back(16'hFFFF);
        href = 1'b0;
        vsync_pulse();
        reg_check("f1_count", A_COUNT, 16'd4);
        bus_write(A_RADDR, 16'h0000);
        for (int i = 0; i < 4; i++) sb_read("f1_rdata");
        reg_check("f1_status", A_STATUS, 16'h0102);
        check("f1_irq", {15'b0, irq}, 16'h0001);

        // Overflow: 20 raw pixels into a 16-word buffer
        bus_write(A_CTRL, 16'h0009);
        check("ctrl_clears_irq", {15'b0, irq}, 16'h0000);
        vsync_pulse();
        href = 1'b1;
        for (int k = 1; k <= 20; k++) send_pixel(24'h00A000 + 24'(k));
        href = 1'b0;
        vsync_pulse();
        reg_check("ovf_status", A_STATUS, 16'h0206);
        reg_check("ovf_count", A_COUNT, 16'd16);

        // Read pointer wrap from DEPTH-1 to 0
        bus_write(A_RADDR, 16'd15);
        sb_q.push_back(16'hA010);
        sb_q.push_back(16'hA001);
        sb_read("wrap_last");
        sb_read("wrap_first");

        // Continuous mode over three frames, then abort
        do_reset();
        bus_write(A_CTRL, 16'h0003);
        vsync_pulse();
        for (int f = 0; f < 3; f++) begin
            href = 1'b1;
            for (int k = 0; k < 10; k++) send_pixel(24'(f * 16 + k));
            href = 1'b0;
            vsync_pulse();
        end
        reg_check("cont_status", A_STATUS, 16'h0303);
        reg_check("cont_count", A_COUNT, 16'd10);
        reg_check("cont_ctrl_rb", A_CTRL, 16'h0002);
        bus_write(A_ABORT, 16'h0000);
        reg_check("abort_status", A_STATUS, 16'h0302);

        // Format conversion table
        foreach (vecs[i]) begin
            bus_write(A_CTRL, 16'h0001 | {12'b0, vecs[i].fmt, 2'b00});
            vsync_pulse();
            href = 1'b1;
            send_pixel(vecs[i].pix);
            sb_q.push_back(vecs[i].exp);
            href = 1'b0;
            vsync_pulse();
            bus_write(A_RADDR, 16'h0000);
            sb_read($sformatf("fmt_vec%0d", i));
        end

        // Reset in the middle of a capture
        bus_write(A_CTRL, 16'h0009);
        vsync_pulse();
        href = 1'b1;
        send_pixel(24'h005555);
        send_pixel(24'h005556);
        do_reset();
        send_pixel(24'h007777);
        send_pixel(24'h007778);
        href = 1'b0;
        vsync_pulse();
        href = 1'b1;
        send_pixel(24'h007779);
        href = 1'b0;
        vsync_pulse();
        reg_check("rstcap_status", A_STATUS, 16'h0000);
        reg_check("rstcap_count", A_COUNT, 16'h0000);
        bus_write(A_RADDR, 16'h0000);
        sb_q.push_back(16'h5555);
        sb_q.push_back(16'h5556);
        sb_read("rstcap_mem0");
        sb_read("rstcap_mem1");

        // Decimation enable bit: honoured only with CAM_DECIMATE_EN
        bus_write(A_CTRL, 16'h0011);
        vsync_pulse();
        href = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send_pixel({5'(k), 19'b0});
`ifdef CAM_DECIMATE_EN
            if ((k % 2) == 0) sb_q.push_back(16'(k << 11));
`else
            if (k < 4) sb_q.push_back(16'(k << 11));
`endif
        end
        href = 1'b0;
        vsync_pulse();
`ifdef CAM_DECIMATE_EN
        reg_check("decim_count", A_COUNT, 16'd4);
        reg_check("decim_ctrl_rb", A_CTRL, 16'h0010);
`else
        reg_check("decim_count", A_COUNT, 16'd8);
        reg_check("decim_ctrl_rb", A_CTRL, 16'h0000);
`endif
        bus_write(A_RADDR, 16'h0000);
        for (int i = 0; i < 4; i++) sb_read("decim_rdata");

        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: got %0d entries left, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
